// File: rtl/board_redraw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : board_redraw_sequencer
// Purpose  : Initiator side of the draw_cell handshake. It walks the 9x9
//            Sudoku board held in a synchronous-read board RAM. For each cell
//            it fetches the digit and the given flag, picks a colour, and
//            issues one start_write transaction to draw_cell. A single-cell
//            redraw request is serviced ahead of the next step of a sweep.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   full_req_i     pulse: redraw all 81 cells
//   cell_req_i     pulse: redraw cell (req_row_i, req_col_i)
//   req_row_i/col  coordinates for cell_req_i, 0..8 (larger values ignored)
//   cursor_row_i/col_i  cursor position, selects COLOR_CURSOR
//   ram_addr_o     board RAM read address (row*9+col)
//   ram_data_i     {given, digit[3:0]}, valid one cycle after ram_addr_o
//   start_write_o  request to draw_cell, held until working_i is seen
//   cell_row_o/cell_col_o/cell_data_o/color_code_o  payload to draw_cell
//   working_i      draw_cell busy flag
//   busy_o         sequencer active or a request pending
//   timeout_err_o  sticky: draw_cell failed to acknowledge a start_write
// ============================================================================
module board_redraw_sequencer #(
  parameter logic [2:0]  COLOR_GIVEN  = 3'd1,
  parameter logic [2:0]  COLOR_USER   = 3'd2,
  parameter logic [2:0]  COLOR_CURSOR = 3'd4,
  parameter int unsigned ACK_TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       full_req_i,
  input  logic       cell_req_i,
  input  logic [3:0] req_row_i,
  input  logic [3:0] req_col_i,
  input  logic [3:0] cursor_row_i,
  input  logic [3:0] cursor_col_i,
  output logic [6:0] ram_addr_o,
  input  logic [4:0] ram_data_i,
  output logic       start_write_o,
  output logic [3:0] cell_row_o,
  output logic [3:0] cell_col_o,
  output logic [3:0] cell_data_o,
  output logic [2:0] color_code_o,
  input  logic       working_i,
  output logic       busy_o,
  output logic       timeout_err_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  // Timer counts 0..ACK_TIMEOUT-1 while start_write is held.
  localparam int unsigned   TMR_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  state_t           state_q;
  logic             full_pend_q, full_pend_d;
  logic             cell_pend_q, cell_pend_d;
  logic [3:0]       req_row_q, req_row_d;
  logic [3:0]       req_col_q, req_col_d;
  logic             sweep_act_q;
  logic [3:0]       sw_row_q, sw_col_q;
  logic [3:0]       cur_row_q, cur_col_q;
  logic [TMR_W-1:0] timer_q;
  logic [6:0]       ram_addr_q;
  logic             start_write_q;
  logic [3:0]       cell_row_q, cell_col_q, cell_data_q;
  logic [2:0]       color_q;
  logic             tmo_err_q;

  // Next-target selection
  logic       pick_valid, pick_cell, pick_full, pick_sweep;
  logic [3:0] pick_row, pick_col;
  logic [3:0] succ_row, succ_col;
  logic       succ_done;
  logic [6:0] pick_addr;
  logic       req_ok;
  logic       timeout_hit;
  logic       advance;
  logic       launch;

  assign req_ok = cell_req_i && (req_row_i <= 4'd8) && (req_col_i <= 4'd8);

  assign timeout_hit = (state_q == S_START) && !working_i && (timer_q == TMR_LAST);

  // advance: the sequencer is free to start its next cell this cycle.
  assign advance = (state_q == S_IDLE) || timeout_hit ||
                   ((state_q == S_WAIT) && !working_i);

  // Priority: single-cell request, then a (re)started sweep, then the
  // running sweep position.
  always_comb begin
    pick_valid = 1'b0;
    pick_cell  = 1'b0;
    pick_full  = 1'b0;
    pick_sweep = 1'b0;
    pick_row   = 4'd0;
    pick_col   = 4'd0;
    if (cell_pend_q) begin
      pick_valid = 1'b1;
      pick_cell  = 1'b1;
      pick_row   = req_row_q;
      pick_col   = req_col_q;
    end else if (full_pend_q) begin
      pick_valid = 1'b1;
      pick_full  = 1'b1;
    end else if (sweep_act_q) begin
      pick_valid = 1'b1;
      pick_sweep = 1'b1;
      pick_row   = sw_row_q;
      pick_col   = sw_col_q;
    end
  end

  assign launch = advance && pick_valid;

  // Sweep position following the picked cell, used only for sweep picks.
  always_comb begin
    succ_done = (pick_row == 4'd8) && (pick_col == 4'd8);
    if (pick_col == 4'd8) begin
      succ_col = 4'd0;
      succ_row = pick_row + 4'd1;
    end else begin
      succ_col = pick_col + 4'd1;
      succ_row = pick_row;
    end
  end

  // row*9 + col as row*8 + row + col, all in 7 bits (max 80).
  assign pick_addr = ({3'b000, pick_row} << 3) + {3'b000, pick_row} + {3'b000, pick_col};

  // Pending flags: a new request in the same cycle as its consumption wins,
  // so nothing is lost.
  always_comb begin
    cell_pend_d = cell_pend_q && !(launch && pick_cell);
    req_row_d   = req_row_q;
    req_col_d   = req_col_q;
    if (req_ok) begin
      cell_pend_d = 1'b1;
      req_row_d   = req_row_i;
      req_col_d   = req_col_i;
    end
    full_pend_d = (full_pend_q && !(launch && pick_full)) || full_req_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      full_pend_q   <= 1'b0;
      cell_pend_q   <= 1'b0;
      req_row_q     <= 4'd0;
      req_col_q     <= 4'd0;
      sweep_act_q   <= 1'b0;
      sw_row_q      <= 4'd0;
      sw_col_q      <= 4'd0;
      cur_row_q     <= 4'd0;
      cur_col_q     <= 4'd0;
      timer_q       <= '0;
      ram_addr_q    <= 7'd0;
      start_write_q <= 1'b0;
      cell_row_q    <= 4'd0;
      cell_col_q    <= 4'd0;
      cell_data_q   <= 4'd0;
      color_q       <= 3'd0;
      tmo_err_q     <= 1'b0;
    end else begin
      full_pend_q <= full_pend_d;
      cell_pend_q <= cell_pend_d;
      req_row_q   <= req_row_d;
      req_col_q   <= req_col_d;

      if (timeout_hit) begin
        tmo_err_q <= 1'b1;
      end

      if (advance) begin
        // IDLE, timed-out START and finished WAIT all converge here.
        start_write_q <= 1'b0;
        if (pick_valid) begin
          state_q    <= S_ADDR;
          ram_addr_q <= pick_addr;
          cur_row_q  <= pick_row;
          cur_col_q  <= pick_col;
          // The sweep pointer moves when a sweep cell is launched, so an
          // interleaved single-cell redraw leaves it untouched.
          if (pick_full || pick_sweep) begin
            sweep_act_q <= !succ_done;
            sw_row_q    <= succ_row;
            sw_col_q    <= succ_col;
          end
        end else begin
          state_q <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_ADDR: begin
            state_q <= S_DATA;
          end
          S_DATA: begin
            cell_row_q  <= cur_row_q;
            cell_col_q  <= cur_col_q;
            cell_data_q <= ram_data_i[3:0];
            if ((cur_row_q == cursor_row_i) && (cur_col_q == cursor_col_i)) begin
              color_q <= COLOR_CURSOR;
            end else if (ram_data_i[4]) begin
              color_q <= COLOR_GIVEN;
            end else begin
              color_q <= COLOR_USER;
            end
            start_write_q <= 1'b1;
            timer_q       <= '0;
            state_q       <= S_START;
          end
          S_START: begin
            if (working_i) begin
              start_write_q <= 1'b0;
              state_q       <= S_WAIT;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          S_WAIT: begin
            state_q <= S_WAIT;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ram_addr_o    = ram_addr_q;
  assign start_write_o = start_write_q;
  assign cell_row_o    = cell_row_q;
  assign cell_col_o    = cell_col_q;
  assign cell_data_o   = cell_data_q;
  assign color_code_o  = color_q;
  assign timeout_err_o = tmo_err_q;
  assign busy_o        = (state_q != S_IDLE) || full_pend_q || cell_pend_q;

endmodule
`default_nettype wire

// File: tb/tb_board_redraw_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_redraw_sequencer
// Purpose  : Self-checking bench for board_redraw_sequencer. A behavioural
//            board/colour model builds the expected transaction stream; a
//            draw_cell responder and a synchronous RAM model drive the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_redraw_sequencer;

  localparam int ACK_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       full_req = 1'b0;
  logic       cell_req = 1'b0;
  logic [3:0] req_row = 4'd0;
  logic [3:0] req_col = 4'd0;
  logic [3:0] cursor_row = 4'hF;
  logic [3:0] cursor_col = 4'hF;
  logic [6:0] ram_addr;
  logic [4:0] ram_data = 5'd0;
  logic       start_write;
  logic [3:0] cell_row, cell_col, cell_data;
  logic [2:0] color_code;
  logic       working = 1'b0;
  logic       busy;
  logic       timeout_err;

  always #5 clk = ~clk;

  board_redraw_sequencer #(
    .COLOR_GIVEN (3'd1),
    .COLOR_USER  (3'd2),
    .COLOR_CURSOR(3'd4),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .full_req_i   (full_req),
    .cell_req_i   (cell_req),
    .req_row_i    (req_row),
    .req_col_i    (req_col),
    .cursor_row_i (cursor_row),
    .cursor_col_i (cursor_col),
    .ram_addr_o   (ram_addr),
    .ram_data_i   (ram_data),
    .start_write_o(start_write),
    .cell_row_o   (cell_row),
    .cell_col_o   (cell_col),
    .cell_data_o  (cell_data),
    .color_code_o (color_code),
    .working_i    (working),
    .busy_o       (busy),
    .timeout_err_o(timeout_err)
  );

  // ---------------- board RAM (one-cycle read latency) ----------------
  logic [4:0] mem [0:127];
  always @(posedge clk) ram_data <= mem[ram_addr];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] dat;
    logic [2:0] clr;
  } txn_t;

  txn_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // What draw_cell must receive for board cell (r,c).
  function automatic txn_t model(input int r, input int c);
    txn_t       t;
    logic [4:0] w;
    w     = mem[r * 9 + c];
    t.row = 4'(r);
    t.col = 4'(c);
    t.dat = w[3:0];
    if (4'(r) == cursor_row && 4'(c) == cursor_col) t.clr = 3'd4;
    else if (w[4])                                  t.clr = 3'd1;
    else                                            t.clr = 3'd2;
    return t;
  endfunction

  // ---------------- draw_cell responder ----------------
  int         ack_delay = 3;
  int         busy_len  = 20;
  int         ack_cnt   = 0;
  int         busy_cnt  = 0;
  bit         rand_mode = 1'b0;
  bit         drop_en   = 1'b0;
  logic [3:0] drop_r = 4'd0;
  logic [3:0] drop_c = 4'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      working  = 1'b0;
      ack_cnt  = 0;
      busy_cnt = 0;
    end else if (working) begin
      if (busy_cnt <= 1) working = 1'b0;
      else               busy_cnt--;
    end else if (start_write && !(drop_en && cell_row == drop_r && cell_col == drop_c)) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        working  = 1'b1;
        busy_cnt = busy_len;
        ack_cnt  = 0;
        if (rand_mode) begin
          ack_delay = $urandom_range(4, 2);
          busy_len  = $urandom_range(8, 2);
        end
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // ---------------- compare process ----------------
  int   n_starts = 0;
  int   sw_len   = 0;
  int   tmo_len  = 0;
  bit   sw_prev  = 1'b0;
  txn_t last_obs = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      sw_prev = 1'b0;
      sw_len  = 0;
    end else begin
      if (start_write) begin
        if (!sw_prev) begin
          n_starts++;
          sw_len = 0;
          check("start_while_working", working, 0);
        end
        sw_len++;
        check("busy_during_start", busy, 1);
        check("txn_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          check("cell_row", cell_row, exp_q[0].row);
          check("cell_col", cell_col, exp_q[0].col);
          check("cell_data", cell_data, exp_q[0].dat);
          check("color_code", color_code, exp_q[0].clr);
        end
      end else if (sw_prev) begin
        check("start_len_le_timeout", sw_len <= ACK_TIMEOUT, 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_obs = '{cell_row, cell_col, cell_data, color_code};
        if (drop_en && cell_row == drop_r && cell_col == drop_c) tmo_len = sw_len;
      end
      sw_prev = start_write;
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_full_now();
    full_req = 1'b1;
    @(negedge clk);
    full_req = 1'b0;
  endtask

  task automatic pulse_cell_now(input logic [3:0] r, input logic [3:0] c);
    cell_req = 1'b1;
    req_row  = r;
    req_col  = c;
    @(negedge clk);
    cell_req = 1'b0;
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (n_starts < target && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("reach_txn", n_starts >= target, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((busy || start_write) && n < 6000);
    check(name, busy, 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic push_sweep(input int from_k, input int to_k);
    for (int k = from_k; k <= to_k; k++) exp_q.push_back(model(k / 9, k % 9));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, lat;
    int ks [3];
    logic [3:0] ir [3];
    logic [3:0] ic [3];
    logic [3:0] rr, rc;

    for (int k = 0; k < 128; k++) mem[k] = 5'd0;
    for (int k = 0; k < 81; k++)  mem[k] = {(k % 2 == 0), 4'(k % 10)};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_start_write", start_write, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_cell_row", cell_row, 0);
    check("rst_cell_col", cell_col, 0);
    check("rst_cell_data", cell_data, 0);
    check("rst_color", color_code, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    // 1: full sweep, ack after 3, busy 20
    push_sweep(0, 80);
    base = n_starts;
    @(negedge clk);
    full_req = 1'b1;
    @(posedge clk);
    #1 full_req = 1'b0;
    lat = 1;
    while (!start_write && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("full_req_latency", lat, 4);
    wait_idle("t1_done");
    check("t1_txn_count", n_starts - base, 81);
    check("t1_working_low_at_idle", working, 0);
    check("t1_last_row", last_obs.row, 8);
    check("t1_last_col", last_obs.col, 8);
    check("t1_last_data", last_obs.dat, 0);
    check("t1_last_color", last_obs.clr, 1);

    // 2: cursor cell redraw
    ack_delay = 2; busy_len = 4;
    cursor_row = 4'd4; cursor_col = 4'd7;
    mem[43] = 5'b0_0110;
    exp_q.push_back(model(4, 7));
    base = n_starts;
    @(negedge clk);
    pulse_cell_now(4'd4, 4'd7);
    wait_idle("t2_done");
    check("t2_txn_count", n_starts - base, 1);
    check("t2_row", last_obs.row, 4);
    check("t2_col", last_obs.col, 7);
    check("t2_data", last_obs.dat, 6);
    check("t2_color", last_obs.clr, 4);

    // 3: cell request interleaved into a sweep at (0,3)
    cursor_row = 4'hF; cursor_col = 4'hF;
    push_sweep(0, 3);
    exp_q.push_back(model(2, 2));
    push_sweep(4, 80);
    base = n_starts;
    @(negedge clk);
    pulse_full_now();
    wait_starts(base + 4);
    pulse_cell_now(4'd2, 4'd2);
    wait_idle("t3_done");
    check("t3_txn_count", n_starts - base, 82);
    check("t3_no_timeout", timeout_err, 0);

    // 4: draw_cell never acknowledges (1,0)
    drop_en = 1'b1; drop_r = 4'd1; drop_c = 4'd0; tmo_len = 0;
    push_sweep(0, 80);
    base = n_starts;
    @(negedge clk);
    pulse_full_now();
    wait_idle("t4_done");
    check("t4_txn_count", n_starts - base, 81);
    check("t4_start_len", tmo_len, 16);
    check("t4_timeout_err", timeout_err, 1);
    drop_en = 1'b0;
    exp_q.push_back(model(0, 0));
    pulse_cell_now(4'd0, 4'd0);
    wait_idle("t4_after");
    check("t4_timeout_sticky", timeout_err, 1);

    // 5: reset in the middle of a start_write
    push_sweep(0, 80);
    base = n_starts;
    pulse_full_now();
    wait_starts(base + 10);
    check("t5_start_before_reset", start_write, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_start_write", start_write, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_timeout_err", timeout_err, 0);
    check("t5_rst_ram_addr", ram_addr, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = n_starts;
    repeat (40) @(negedge clk);
    check("t5_no_resume", n_starts - base, 0);
    check("t5_busy_after", busy, 0);

    // 6: out-of-range cell requests
    base = n_starts;
    pulse_cell_now(4'd9, 4'd0);
    check("t6_busy_row9", busy, 0);
    pulse_cell_now(4'd3, 4'd12);
    check("t6_busy_col12", busy, 0);
    repeat (10) @(negedge clk);
    check("t6_no_start", n_starts - base, 0);

    // 7: random board, random handshake timing, three random interleaves
    rand_mode = 1'b1;
    for (int k = 0; k < 81; k++) mem[k] = 5'($urandom_range(31, 0));
    cursor_row = 4'($urandom_range(8, 0));
    cursor_col = 4'($urandom_range(8, 0));
    ks[0] = $urandom_range(20, 0);
    ks[1] = ks[0] + $urandom_range(25, 1);
    ks[2] = ks[1] + $urandom_range(25, 1);
    for (int i = 0; i < 3; i++) begin
      ir[i] = 4'($urandom_range(8, 0));
      ic[i] = 4'($urandom_range(8, 0));
    end
    for (int k = 0; k < 81; k++) begin
      exp_q.push_back(model(k / 9, k % 9));
      for (int i = 0; i < 3; i++)
        if (ks[i] == k) exp_q.push_back(model(ir[i], ic[i]));
    end
    base = n_starts;
    pulse_full_now();
    for (int i = 0; i < 3; i++) begin
      wait_starts(base + ks[i] + i + 1);
      pulse_cell_now(ir[i], ic[i]);
    end
    wait_idle("t7_done");
    check("t7_txn_count", n_starts - base, 84);

    // 8: full_req mid-sweep restarts from (0,0) after the current cell
    push_sweep(0, 4);
    push_sweep(0, 80);
    base = n_starts;
    pulse_full_now();
    wait_starts(base + 5);
    pulse_full_now();
    wait_idle("t8_done");
    check("t8_txn_count", n_starts - base, 86);

    // 9: random single-cell requests from idle, some out of range
    for (int i = 0; i < 8; i++) begin
      rr = 4'($urandom_range(10, 0));
      rc = 4'($urandom_range(10, 0));
      if (rr <= 4'd8 && rc <= 4'd8) exp_q.push_back(model(rr, rc));
      base = n_starts;
      pulse_cell_now(rr, rc);
      wait_idle("t9_done");
      check("t9_txn_count", n_starts - base, (rr <= 4'd8 && rc <= 4'd8) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_redraw_sequencer.md
Name: board_redraw_sequencer

Overview:
Initiator side of the draw_cell cell-drawing handshake. On request it walks the 9x9 Sudoku board stored in board RAM. It fetches each cell's digit and given flag, picks a colour code, and issues one start_write transaction per cell to draw_cell. It also supports a single-cell redraw (e.g. after a keypress), which takes priority over the next step of a full-board sweep.

Parameters:
COLOR_GIVEN, 3'd1, colour_code for a pre-filled (given) digit
COLOR_USER, 3'd2, colour_code for a player-entered digit or an empty cell
COLOR_CURSOR, 3'd4, colour_code for the cell under the cursor; overrides the other two
ACK_TIMEOUT, 16, max cycles to wait for working to rise after start_write asserts

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
full_req  in  1  single-cycle pulse: redraw all 81 cells
cell_req  in  1  single-cycle pulse: redraw the one cell at req_row/req_col
req_row  in  4  row for cell_req, 0..8
req_col  in  4  column for cell_req, 0..8
cursor_row  in  4  current cursor row
cursor_col  in  4  current cursor column
ram_addr  out  7  board RAM read address = row*9+col
ram_data  in  5  {given, digit[3:0]}, valid one cycle after ram_addr
start_write  out  1  request to draw_cell
cell_row  out  4  row to draw_cell
cell_col  out  4  column to draw_cell
cell_data  out  4  digit to draw_cell (0 = blank)
color_code  out  3  colour to draw_cell
working  in  1  draw_cell busy flag
busy  out  1  sequencer active (not IDLE)
timeout_err  out  1  sticky; set when draw_cell never acknowledges a start_write

Behaviour:
- Reset (async, rst_n=0): state IDLE; start_write=0, busy=0, timeout_err=0; cell_row, cell_col, cell_data, color_code, ram_addr all 0; pending flags cleared. Reset mid-transaction drops start_write immediately. No resume after reset.
- Pending flags:
  - full_req sets full_pend.
  - cell_req sets cell_pend and latches req_row/req_col.
  - A cell_req arriving while cell_pend is already set overwrites the coordinates (last request wins).
  - Requests are captured in any state.
- Request coordinates >8 are ignored (flag not set).
- States: IDLE, ADDR, DATA, START, WAIT_DONE.
- IDLE → ADDR when any pend flag is set.
  - cell_pend has priority: target = latched coordinates; clear cell_pend.
  - Otherwise target = sweep counter (row,col), starting at (0,0); full_pend clears when the sweep begins.
- ADDR: drive ram_addr = row*9+col (7-bit, max 80); go to DATA.
- DATA:
  - Register cell_row, cell_col, cell_data = ram_data[3:0].
  - color_code = COLOR_CURSOR if (row,col)==cursor, else COLOR_GIVEN if ram_data[4], else COLOR_USER.
  - Go to START.
- START:
  - Assert start_write and hold it with stable cell_* and color_code.
  - When working=1 is sampled, deassert start_write and go to WAIT_DONE.
  - If ACK_TIMEOUT cycles elapse without working, set timeout_err, drop start_write, and advance as if the cell completed.
- WAIT_DONE: wait for working=0, then advance:
  - Sweep: col increments 0..8; at col=8, col←0 and row increments; after (8,8), sweep ends.
  - A pending cell_pend is serviced before the next sweep cell (the sweep position is preserved).
  - When nothing is left → IDLE.
- full_req during an active sweep restarts the sweep at (0,0) after the current cell finishes.
- Latency: full_req pulse → start_write high is 4 cycles (capture, IDLE, ADDR, DATA).
- busy = (state != IDLE) || any pend flag.
- cell_* outputs hold their last value in IDLE.
- Exactly one start_write transaction per cell; start_write is never asserted while working=1 from the previous cell.

Test Plan:
1. Reset, preload RAM[k]=k%10 with given=1 on even k; full_req pulse; draw_cell model acks after 3 cycles and is busy 20 cycles → exactly 81 transactions in order (0,0)…(8,8); cell_data=k%10; color_code=1 on even k, 2 on odd k; busy falls after the last working falls.
2. Cursor at (4,7), single cell_req row=4 col=7 with RAM[43]=5'b0_0110 → one transaction: cell_row=4, cell_col=7, cell_data=6, color_code=4.
3. cell_req (2,2) issued while the sweep is drawing (0,3) → next transaction is (2,2), then the sweep resumes at (0,4); total 82 transactions.
4. draw_cell model never raises working on cell (1,0) → start_write drops after 16 cycles, timeout_err=1 and stays sticky, sweep continues at (1,1).
5. Assert rst_n=0 while start_write=1 mid-sweep → start_write, busy, timeout_err are 0 in the same cycle; after release, no activity until a new request.
6. cell_req with req_row=9 → ignored: busy stays 0, no start_write.
